// File: rtl/load_store_unit.sv
// RV32 load/store unit bridging a core request port to a word-wide memory port.
// Define LSU_MISALIGN_TRAP_EN to return an error for misaligned halfword/word accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    ofs_q, ofs_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          illegal;
  logic          misaligned;
  logic [1:0]    ofs;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;

  // Request decode: legality, effective byte offset and store lane placement.
  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase

    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01) begin
      misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned = |req_addr[1:0];
    end
`endif

    case (req_funct3[1:0])
      2'b10: begin
        ofs     = 2'b00;
        st_mask = 4'b1111;
        st_data = req_wdata;
      end
      2'b01: begin
        ofs     = {req_addr[1], 1'b0};
        st_mask = 4'b0011 << ofs;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        ofs     = req_addr[1:0];
        st_mask = 4'b0001 << ofs;
        st_data = {4{req_wdata[7:0]}};
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {ofs_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'h000000, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'h0000, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    ofs_d   = ofs_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          ofs_d   = ofs;
          addr_d  = {req_addr[31:2], 2'b00};
          wmask_d = req_we ? st_mask : 4'b0000;
          wdata_d = req_we ? st_data : 32'h0;
          cnt_d   = '0;
          rdata_d = 32'h0;
          if (illegal || misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      // mem_done is deliberately not looked at here: it can still be high from the previous access.
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          rdata_d = we_q ? 32'h0 : ld_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      ofs_q   <= 2'b00;
      addr_q  <= 32'h0;
      wmask_q <= 4'b0000;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      ofs_q   <= ofs_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign mem_wstrobe = (state_q == REQ) && we_q;
  assign mem_rstrobe = (state_q == REQ) && !we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-masked word memory model.
// Build with LSU_MISALIGN_TRAP_EN defined to check the trapping variant.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrobe;
  logic        mem_rstrobe;
  logic [31:0] mem_rdata;
  logic        mem_done;

  logic        mem_dead;
  logic        mem_sticky;
  logic [31:0] mem [0:255];

  int tests_run = 0;
  int tests_failed = 0;

  // Results of the most recent access
  int          lat, nw, nr;
  logic [31:0] rd, ma, mw;
  logic [3:0]  mm;
  logic        er, after_ok;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_wstrobe(mem_wstrobe),
    .mem_rstrobe(mem_rstrobe),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  // done rises the cycle after a strobe; sticky mode leaves it high afterwards
  always @(posedge clk) begin
    if (mem_wstrobe) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (!rst_n) mem_done <= 1'b0;
    else if (mem_wstrobe || mem_rstrobe) mem_done <= !mem_dead;
    else if (!mem_sticky) mem_done <= 1'b0;
  end

  task automatic do_access(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nw = 0; nr = 0; ma = 32'h0; mw = 32'h0; mm = 4'h0;
    while (lat < 40) begin
      if (mem_wstrobe) begin nw++; ma = mem_addr; mm = mem_wmask; mw = mem_wdata; end
      if (mem_rstrobe) begin nr++; ma = mem_addr; end
      if (resp_valid) break;
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    after_ok = !resp_valid && req_ready;
    $display("[TB] access we=%0b f3=%03b addr=%08h wdata=%08h -> lat=%0d nw=%0d nr=%0d maddr=%08h wmask=%04b mwdata=%08h rdata=%08h err=%0b",
             we, f3, addr, wd, lat, nw, nr, ma, mm, mw, rd, er);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_dead = 1'b0; mem_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wstrobe !== 1'b0 || mem_rstrobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready=%b resp_valid=%b wstb=%b rstb=%b, want 1 0 0 0",
               req_ready, resp_valid, mem_wstrobe, mem_rstrobe);
    end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: maddr=%08h mwdata=%08h wmask=%04b rdata=%08h err=%b, want all 0",
               mem_addr, mem_wdata, mem_wmask, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_byte();
    do_access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB);
    tests_run++;
    if (ma !== 32'h100 || mm !== 4'b1000 || mw !== 32'hABAB_ABAB) begin
      tests_failed++;
      $display("FAIL sb_port: maddr=%08h wmask=%04b wdata=%08h, want 00000100 1000 abababab", ma, mm, mw);
    end
    tests_run++;
    if (lat !== 2 || nw !== 1 || nr !== 0 || er !== 1'b0 || rd !== 32'h0 || !after_ok) begin
      tests_failed++;
      $display("FAIL sb_resp: lat=%0d nw=%0d nr=%0d err=%b rdata=%08h after=%b, want 2 1 0 0 00000000 1",
               lat, nw, nr, er, rd, after_ok);
    end
  endtask

  task automatic test_load_sign();
    do_access(1'b1, 3'b010, 32'h0000_0100, 32'h0080_0000);
    tests_run++;
    if (mm !== 4'b1111 || mw !== 32'h0080_0000 || ma !== 32'h100) begin
      tests_failed++;
      $display("FAIL sw_port: maddr=%08h wmask=%04b wdata=%08h, want 00000100 1111 00800000", ma, mm, mw);
    end
    do_access(1'b0, 3'b000, 32'h0000_0102, 32'h0);
    tests_run++;
    if (rd !== 32'hFFFF_FF80 || er !== 1'b0 || nr !== 1 || nw !== 0 || ma !== 32'h100) begin
      tests_failed++;
      $display("FAIL lb: rdata=%08h err=%b nr=%0d nw=%0d maddr=%08h, want ffffff80 0 1 0 00000100", rd, er, nr, nw, ma);
    end
    do_access(1'b0, 3'b100, 32'h0000_0102, 32'h0);
    tests_run++;
    if (rd !== 32'h0000_0080 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL lbu: rdata=%08h err=%b, want 00000080 0", rd, er);
    end
  endtask

  task automatic test_halfword();
    do_access(1'b1, 3'b010, 32'h0000_0200, 32'h8001_7FFF);
    do_access(1'b0, 3'b001, 32'h0000_0202, 32'h0);
    tests_run++;
    if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL lh_hi: rdata=%08h err=%b, want ffff8001 0", rd, er);
    end
    do_access(1'b0, 3'b101, 32'h0000_0202, 32'h0);
    tests_run++;
    if (rd !== 32'h0000_8001 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL lhu_hi: rdata=%08h err=%b, want 00008001 0", rd, er);
    end
    do_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678);
    tests_run++;
    if (mm !== 4'b1100 || mw !== 32'h5678_5678 || ma !== 32'h200) begin
      tests_failed++;
      $display("FAIL sh_port: maddr=%08h wmask=%04b wdata=%08h, want 00000200 1100 56785678", ma, mm, mw);
    end
    do_access(1'b0, 3'b001, 32'h0000_0200, 32'h0);
    tests_run++;
    if (rd !== 32'h0000_7FFF) begin
      tests_failed++;
      $display("FAIL lh_lo: rdata=%08h, want 00007fff", rd);
    end
    do_access(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tests_run++;
    if (rd !== 32'h5678_7FFF) begin
      tests_failed++;
      $display("FAIL lw_after_sh: rdata=%08h, want 56787fff", rd);
    end
  endtask

  task automatic test_stale_done();
    mem_sticky = 1'b1;
    do_access(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
    do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    mem_sticky = 1'b0;
    tests_run++;
    if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || nr !== 1) begin
      tests_failed++;
      $display("FAIL stale_done: lat=%0d rdata=%08h err=%b nr=%0d, want 2 deadbeef 0 1", lat, rd, er, nr);
    end
  endtask

  task automatic test_misalign();
    do_access(1'b0, 3'b001, 32'h0000_0041, 32'h0);
    tests_run++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (er !== 1'b1 || nr !== 0 || nw !== 0 || lat !== 0 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL lh_mis: err=%b nr=%0d nw=%0d lat=%0d rdata=%08h, want 1 0 0 0 00000000", er, nr, nw, lat, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'hFFFF_BEEF || ma !== 32'h40 || lat !== 2) begin
      tests_failed++;
      $display("FAIL lh_mis: err=%b rdata=%08h maddr=%08h lat=%0d, want 0 ffffbeef 00000040 2", er, rd, ma, lat);
    end
`endif
    do_access(1'b0, 3'b010, 32'h0000_0043, 32'h0);
    tests_run++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (er !== 1'b1 || nr !== 0 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL lw_mis: err=%b nr=%0d rdata=%08h, want 1 0 00000000", er, nr, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL lw_mis: err=%b rdata=%08h, want 0 deadbeef", er, rd);
    end
`endif
    do_access(1'b1, 3'b001, 32'h0000_0043, 32'h0000_CAFE);
    tests_run++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (er !== 1'b1 || nw !== 0) begin
      tests_failed++;
      $display("FAIL sh_mis: err=%b nw=%0d, want 1 0", er, nw);
    end
`else
    if (er !== 1'b0 || nw !== 1 || mm !== 4'b1100 || mw !== 32'hCAFE_CAFE) begin
      tests_failed++;
      $display("FAIL sh_mis: err=%b nw=%0d wmask=%04b wdata=%08h, want 0 1 1100 cafecafe", er, nw, mm, mw);
    end
`endif
    do_access(1'b1, 3'b000, 32'h0000_0041, 32'h0000_0011);
    tests_run++;
    if (er !== 1'b0 || nw !== 1 || mm !== 4'b0010 || mw !== 32'h1111_1111) begin
      tests_failed++;
      $display("FAIL sb_ofs1: err=%b nw=%0d wmask=%04b wdata=%08h, want 0 1 0010 11111111", er, nw, mm, mw);
    end
  endtask

  task automatic test_illegal();
    do_access(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    tests_run++;
    if (er !== 1'b1 || nr !== 0 || nw !== 0 || lat !== 0 || rd !== 32'h0 || !after_ok) begin
      tests_failed++;
      $display("FAIL illegal_load: err=%b nr=%0d nw=%0d lat=%0d rdata=%08h after=%b, want 1 0 0 0 00000000 1",
               er, nr, nw, lat, rd, after_ok);
    end
    do_access(1'b1, 3'b100, 32'h0000_0040, 32'h0000_00FF);
    tests_run++;
    if (er !== 1'b1 || nw !== 0 || nr !== 0 || lat !== 0) begin
      tests_failed++;
      $display("FAIL illegal_store: err=%b nw=%0d nr=%0d lat=%0d, want 1 0 0 0", er, nw, nr, lat);
    end
  endtask

  task automatic test_timeout();
    mem_dead = 1'b1;
    do_access(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    mem_dead = 1'b0;
    tests_run++;
    if (lat !== 17 || er !== 1'b1 || rd !== 32'h0 || nr !== 1) begin
      tests_failed++;
      $display("FAIL timeout: lat=%0d err=%b rdata=%08h nr=%0d, want 17 1 00000000 1", lat, er, rd, nr);
    end
    do_access(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tests_run++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h5678_7FFF) begin
      tests_failed++;
      $display("FAIL after_timeout: lat=%0d err=%b rdata=%08h, want 2 0 56787fff", lat, er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1;
    logic        ok;
    ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0200; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0000_0100;
    if (!(mem_rstrobe && mem_addr == 32'h200 && !req_ready)) ok = 1'b0;
    @(negedge clk);
    if (!(!mem_rstrobe && mem_addr == 32'h200 && !req_ready)) ok = 1'b0;
    @(negedge clk);
    r1 = resp_rdata;
    if (!(resp_valid && !req_ready)) ok = 1'b0;
    @(negedge clk);
    if (!(req_ready && !resp_valid)) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (!(mem_rstrobe && mem_addr == 32'h100)) ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (!(resp_valid && resp_rdata == 32'h0080_0000)) ok = 1'b0;
    $display("[TB] back_to_back first=%08h second=%08h ok=%b", r1, resp_rdata, ok);
    tests_run++;
    if (!ok || r1 !== 32'h5678_7FFF) begin
      tests_failed++;
      $display("FAIL back_to_back: ok=%b first=%08h, want 1 56787fff", ok, r1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    mem_dead = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0040; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (mem_wstrobe !== 1'b0 || mem_rstrobe !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: wstb=%b rstb=%b resp_valid=%b ready=%b maddr=%08h, want 0 0 0 1 00000000",
               mem_wstrobe, mem_rstrobe, resp_valid, req_ready, mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_dead = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b, want 1", req_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_resp: resp_valid seen=%b, want 0", seen);
    end
    do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    tests_run++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0080_0000) begin
      tests_failed++;
      $display("FAIL after_reset: lat=%0d err=%b rdata=%08h, want 2 0 00800000", lat, er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_sign();
    test_halfword();
    test_stale_done();
    test_misalign();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
